decode_stage_q: RTL and testbench
=================================

Name: decode_stage_q

Overview:
- Parametrised successor to the combinational decode step.
- Buffers fetched instructions in a circular queue.
- Detects RAW hazards against a configurable number of forwarding sources and stalls on not-yet-available data (load-use).
- Resolves operands with priority forwarding and emits a registered ID/EX slot under valid/ready handshake.
- Sits between fetch and execute; flushable by the branch/trap redirect.

Parameters:
XLEN, 64, data/PC width
NUM_FWD, 3, forwarding sources; index 0 = youngest, highest priority
QDEPTH, 4, instruction queue entries; power of two, >=2

Ports:
clk  in  1  clock
reset  in  1  active-low synchronous reset
flush  in  1  discard queue and output slot
in_valid  in  1  fetch offers instruction
in_ready  out  1  queue can accept
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction PC
fwd_valid  in  NUM_FWD  source i will write a register
fwd_pending  in  NUM_FWD  source i result not yet available
fwd_addr  in  NUM_FWD*5  destination register of source i
fwd_data  in  NUM_FWD*XLEN  result of source i, meaningful when not pending
rf_raddr1  out  5  regfile read address, rs1 of queue head
rf_raddr2  out  5  regfile read address, rs2 of queue head
rf_rdata1  in  XLEN  combinational read data 1
rf_rdata2  in  XLEN  combinational read data 2
out_valid  out  1  ID/EX slot valid
out_ready  in  1  execute accepts slot
out_inst  out  32  instruction
out_pc  out  XLEN  PC
out_rs1_value  out  XLEN  resolved operand 1
out_rs2_value  out  XLEN  resolved operand 2
out_illegal  out  1  illegal-instruction trap, code 2
stall_cycles  out  32  hazard-stall counter, see optional feature

Behaviour:
- Reset (reset==0 at posedge): queue empty, count 0, out_valid 0, all out_* data 0, stall_cycles 0.
- in_ready = (count != QDEPTH). It does not depend on a same-cycle dequeue.
- Enqueue fires when in_valid && in_ready && !flush.
- Simultaneous enqueue and dequeue leaves count unchanged.
- Pointers wrap modulo QDEPTH.
- Source usage:
  - rs1 used except for LUI (0110111), AUIPC (0010111), JAL (1101111).
  - rs2 used only for opcodes 0110011, 0111011, 0100011, 1100011.
- Forwarding match on source i: fwd_valid[i] && fwd_addr[i]!=0 && fwd_addr[i]==rs && rs is used.
- Hazard: the lowest-index matching source for rs1 or rs2 has fwd_pending=1.
- Operand value: fwd_data of the lowest-index match; otherwise rf_rdata. x0 always reads 0.
- Slot free = !out_valid || out_ready.
- Issue fires when queue non-empty && !hazard && slot free && !flush. On issue:
  - Head is dequeued.
  - out_* are loaded at that edge; out_valid=1.
- If the slot is free and nothing issues, out_valid is cleared to 0.
- If out_valid && !out_ready, all out_* hold stable.
- Latency: enqueue at edge E0 → earliest out_valid after E1. Sustained throughput is 1 per cycle.
- out_illegal=1 when any of the following holds; illegal instructions still issue (trap handled downstream):
  - inst[1:0]!=2'b11, or
  - opcode not in {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0011011, 0111011, 1110011, 0001111}.
- Flush:
  - Next edge: count 0, out_valid 0.
  - Same-cycle in_valid is dropped.
  - Flush has priority over issue and enqueue.
- Reset has priority over flush.

Optional Feature:
- DECODE_STALL_CNT_EN defined: stall_cycles increments by 1 on each cycle with a non-empty queue, hazard=1 and !flush. It saturates at 32'hFFFF_FFFF and is cleared by reset only.
- Undefined: stall_cycles tied to 0 and no counter logic is built.

Decomposition:
- Package decode_pkg:
  - Opcode constants.
  - ILLEGAL_INST_CODE=2.
  - Functions uses_rs1(inst), uses_rs2(inst), is_legal_opcode(inst).
- Sub-module decode_queue: parametrised circular FIFO with XLEN+32 payload, count, full/empty, flush.
- Hazard/forward/issue logic stays in decode_stage_q.

Test Plan:
- Reset then enqueue ADD x3,x1,x2 (0x002081B3), rf_rdata1=5, rf_rdata2=7, no fwd, out_ready=1 → out_valid after 2nd edge; out_rs1_value=5, out_rs2_value=7, out_illegal=0.
- Same ADD with fwd0 and fwd2 both on x1, not pending, data 0xAA and 0xBB → out_rs1_value=0xAA (index 0 wins).
- Same ADD with fwd1 on x2 pending for 3 cycles → out_valid stays 0 those cycles; issues the cycle after pending drops; stall_cycles=3 (macro on) or 0 (macro off).
- out_ready=0 and 5 back-to-back inputs with QDEPTH=4:
  - in_ready drops once count=4; out_* stable.
  - Releasing out_ready drains all 5 in order, 1 per cycle, PCs monotonic.
- Enqueue 0x0000007F (bad opcode) then 0x00000000 → both issue with out_illegal=1.
- Queue of 3 entries, flush asserted together with in_valid → next cycle count 0, out_valid 0; the dropped instruction never appears.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: RV64 major opcodes, trap code and
// source-usage / legality helpers used by the decode stage.
package decode_pkg;

  typedef enum logic [6:0] {
    OP_LUI      = 7'b0110111,
    OP_AUIPC    = 7'b0010111,
    OP_JAL      = 7'b1101111,
    OP_JALR     = 7'b1100111,
    OP_BRANCH   = 7'b1100011,
    OP_LOAD     = 7'b0000011,
    OP_STORE    = 7'b0100011,
    OP_OPIMM    = 7'b0010011,
    OP_OP       = 7'b0110011,
    OP_OPIMM32  = 7'b0011011,
    OP_OP32     = 7'b0111011,
    OP_SYSTEM   = 7'b1110011,
    OP_MISCMEM  = 7'b0001111
  } opcode_e;

  localparam int unsigned ILLEGAL_INST_CODE = 32'd2;

  // rs1 is read by everything except the upper-immediate and JAL forms
  function automatic logic uses_rs1(input logic [31:0] inst);
    logic r;
    case (inst[6:0])
      OP_LUI, OP_AUIPC, OP_JAL: r = 1'b0;
      default:                  r = 1'b1;
    endcase
    return r;
  endfunction

  // rs2 is read only by register-register ALU ops, stores and branches
  function automatic logic uses_rs2(input logic [31:0] inst);
    logic r;
    case (inst[6:0])
      OP_OP, OP_OP32, OP_STORE, OP_BRANCH: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_legal_opcode(input logic [31:0] inst);
    logic r;
    case (inst[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
      OP_OPIMM, OP_OP, OP_OPIMM32, OP_OP32, OP_SYSTEM, OP_MISCMEM: r = 1'b1;
      default:                                                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_queue.sv
// Circular instruction FIFO between fetch and decode. Flush empties it in
// one edge; pointers wrap naturally because QDEPTH is a power of two.
module decode_queue #(
  parameter int W      = 96,
  parameter int QDEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);
  import decode_pkg::*;

  localparam int AW = $clog2(QDEPTH);

  logic [W-1:0]  r_mem [QDEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  // Pointer and occupancy tracking; flush outranks push/pop
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (reset && push && !flush) begin
      r_mem[r_wptr] <= push_data;
    end
  end

  assign head_data = r_mem[r_rptr];
  assign full      = (r_count == (AW+1)'(QDEPTH));
  assign empty     = (r_count == '0);

endmodule

// File: rtl/decode_stage_q.sv
// Queued decode stage: buffers fetched instructions, checks RAW hazards
// against NUM_FWD forwarding sources (index 0 youngest / highest priority),
// resolves operands and issues into a registered ID/EX slot.
// Optional build macro: DECODE_STALL_CNT_EN enables the hazard-stall counter.
module decode_stage_q
  import decode_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_FWD = 3,
  parameter int QDEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_inst,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  input  logic [NUM_FWD*5-1:0]    fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic [4:0]              rf_raddr1,
  output logic [4:0]              rf_raddr2,
  input  logic [XLEN-1:0]         rf_rdata1,
  input  logic [XLEN-1:0]         rf_rdata2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_inst,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_rs1_value,
  output logic [XLEN-1:0]         out_rs2_value,
  output logic                    out_illegal,
  output logic [31:0]             stall_cycles
);

  logic                 w_q_full, w_q_empty, w_push, w_issue, w_slot_free;
  logic [XLEN+31:0]     w_head;
  logic [31:0]          w_head_inst;
  logic [XLEN-1:0]      w_head_pc;
  logic [4:0]           w_rs1, w_rs2;
  logic                 w_use1, w_use2, w_haz1, w_haz2, w_hazard, w_illegal;
  logic [XLEN-1:0]      w_rs1_val, w_rs2_val;

  logic                 r_out_valid, r_out_illegal;
  logic [31:0]          r_out_inst;
  logic [XLEN-1:0]      r_out_pc, r_out_rs1, r_out_rs2;

  assign in_ready = !w_q_full;
  assign w_push   = in_valid && !w_q_full && !flush;

  decode_queue #(.W(XLEN+32), .QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (w_push),
    .push_data ({in_pc, in_inst}),
    .pop       (w_issue),
    .head_data (w_head),
    .full      (w_q_full),
    .empty     (w_q_empty)
  );

  assign w_head_inst = w_head[31:0];
  assign w_head_pc   = w_head[XLEN+31:32];
  assign w_rs1       = w_head_inst[19:15];
  assign w_rs2       = w_head_inst[24:20];
  assign w_use1      = uses_rs1(w_head_inst);
  assign w_use2      = uses_rs2(w_head_inst);
  assign rf_raddr1   = w_rs1;
  assign rf_raddr2   = w_rs2;
  assign w_illegal   = (w_head_inst[1:0] != 2'b11) || !is_legal_opcode(w_head_inst);

  // Priority forwarding: scan oldest to youngest so the lowest index wins
  always_comb begin
    w_rs1_val = rf_rdata1;
    w_rs2_val = rf_rdata2;
    w_haz1    = 1'b0;
    w_haz2    = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_addr[i*5 +: 5] != 5'd0) &&
          (fwd_addr[i*5 +: 5] == w_rs1) && w_use1) begin
        w_rs1_val = fwd_data[i*XLEN +: XLEN];
        w_haz1    = fwd_pending[i];
      end else begin
        w_rs1_val = w_rs1_val;
      end
      if (fwd_valid[i] && (fwd_addr[i*5 +: 5] != 5'd0) &&
          (fwd_addr[i*5 +: 5] == w_rs2) && w_use2) begin
        w_rs2_val = fwd_data[i*XLEN +: XLEN];
        w_haz2    = fwd_pending[i];
      end else begin
        w_rs2_val = w_rs2_val;
      end
    end
    if (w_rs1 == 5'd0) w_rs1_val = '0;
    else               w_rs1_val = w_rs1_val;
    if (w_rs2 == 5'd0) w_rs2_val = '0;
    else               w_rs2_val = w_rs2_val;
  end

  assign w_hazard    = w_haz1 || w_haz2;
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_issue     = !w_q_empty && !w_hazard && w_slot_free && !flush;

  // ID/EX slot: load on issue, drop when consumed, hold under backpressure
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid   <= 1'b0;
      r_out_inst    <= 32'd0;
      r_out_pc      <= '0;
      r_out_rs1     <= '0;
      r_out_rs2     <= '0;
      r_out_illegal <= 1'b0;
    end else if (flush) begin
      r_out_valid   <= 1'b0;
    end else if (w_issue) begin
      r_out_valid   <= 1'b1;
      r_out_inst    <= w_head_inst;
      r_out_pc      <= w_head_pc;
      r_out_rs1     <= w_rs1_val;
      r_out_rs2     <= w_rs2_val;
      r_out_illegal <= w_illegal;
    end else if (w_slot_free) begin
      r_out_valid   <= 1'b0;
    end else begin
      r_out_valid   <= r_out_valid;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_inst      = r_out_inst;
  assign out_pc        = r_out_pc;
  assign out_rs1_value = r_out_rs1;
  assign out_rs2_value = r_out_rs2;
  assign out_illegal   = r_out_illegal;

`ifdef DECODE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles the head instruction waits on pending data
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= 32'd0;
    end else if (!w_q_empty && w_hazard && !flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cycles = r_stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_decode_stage_q.sv
// Scoreboard bench for decode_stage_q: expected ID/EX slots are queued when
// instructions are offered and compared when the slot is consumed.
module tb_decode_stage_q;

  localparam int XLEN = 64;
  localparam int NF   = 3;
  localparam logic [31:0] ADD = 32'h002081B3;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_inst, out_inst, stall_cycles;
  logic [XLEN-1:0] in_pc, out_pc, out_rs1_value, out_rs2_value, rf_rdata1, rf_rdata2;
  logic [NF-1:0] fwd_valid, fwd_pending;
  logic [NF*5-1:0] fwd_addr;
  logic [NF*XLEN-1:0] fwd_data;
  logic [4:0] rf_raddr1, rf_raddr2;

  typedef struct {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic            ill;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int n_xfer = 0;
  logic [XLEN-1:0] next_pc = 64'h1000;
  logic [XLEN-1:0] last_pc = 64'h0;
  logic hold_r = 1'b0;
  logic [31:0] h_inst;
  logic [XLEN-1:0] h_pc, h_r1, h_r2;
  int base;
  logic [31:0] exp_stall;

  always #5 clk = ~clk;

  decode_stage_q #(.XLEN(XLEN), .NUM_FWD(NF), .QDEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value),
    .out_illegal(out_illegal), .stall_cycles(stall_cycles)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // offer one instruction, waiting for in_ready, and queue its expected slot
  task automatic send(input logic [31:0] inst, input logic [XLEN-1:0] r1,
                      input logic [XLEN-1:0] r2, input logic ill);
    exp_t e;
    logic acc;
    int n;
    e.inst = inst; e.pc = next_pc; e.r1 = r1; e.r2 = r2; e.ill = ill;
    sb.push_back(e);
    in_valid = 1'b1; in_inst = inst; in_pc = next_pc;
    next_pc = next_pc + 64'd4;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      acc = in_ready;
      step();
      n++;
    end
    if (!acc) check_eq("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  // consumer side: hold stability and scoreboard comparison on transfer
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (hold_r && out_valid) begin
        check_eq("hold_inst", {32'd0, out_inst}, {32'd0, h_inst});
        check_eq("hold_pc", out_pc, h_pc);
        check_eq("hold_rs1", out_rs1_value, h_r1);
        check_eq("hold_rs2", out_rs2_value, h_r2);
      end
      if (out_valid && out_ready) begin
        n_xfer++;
        if (sb.size() == 0) begin
          check_eq("unexpected_out", {32'd0, out_inst}, 64'hDEAD);
        end else begin
          e = sb.pop_front();
          check_eq("out_inst", {32'd0, out_inst}, {32'd0, e.inst});
          check_eq("out_pc", out_pc, e.pc);
          check_eq("out_rs1", out_rs1_value, e.r1);
          check_eq("out_rs2", out_rs2_value, e.r2);
          check_eq("out_illegal", {63'd0, out_illegal}, {63'd0, e.ill});
          check_eq("pc_monotonic", {63'd0, (out_pc > last_pc)}, 64'd1);
          last_pc = out_pc;
        end
      end
      hold_r = out_valid && !out_ready;
      h_inst = out_inst; h_pc = out_pc; h_r1 = out_rs1_value; h_r2 = out_rs2_value;
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = 32'd0; in_pc = '0;
    fwd_valid = '0; fwd_pending = '0; fwd_addr = '0; fwd_data = '0;
    rf_rdata1 = 64'd5; rf_rdata2 = 64'd7; out_ready = 1'b1;
    step(); step();
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_out_inst", {32'd0, out_inst}, 64'd0);
    check_eq("rst_out_pc", out_pc, 64'd0);
    check_eq("rst_out_rs1", out_rs1_value, 64'd0);
    check_eq("rst_out_ill", {63'd0, out_illegal}, 64'd0);
    check_eq("rst_stall", {32'd0, stall_cycles}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    reset = 1'b1;
    step();

    // basic ADD from the register file, latency: valid only after second edge
    send(ADD, 64'd5, 64'd7, 1'b0);
    check_eq("lat_e0_valid", {63'd0, out_valid}, 64'd0);
    step();
    check_eq("lat_e1_valid", {63'd0, out_valid}, 64'd1);
    step(); step();
    check_eq("t1_drained", 64'(sb.size()), 64'd0);

    // two sources on x1: index 0 must win
    fwd_valid = 3'b101;
    fwd_addr = {5'd1, 5'd0, 5'd1};
    fwd_data = {64'hBB, 64'h0, 64'hAA};
    send(ADD, 64'hAA, 64'd7, 1'b0);
    step(); step(); step();
    check_eq("t2_drained", 64'(sb.size()), 64'd0);

    // load-use on x2 through source 1, pending for three cycles
    fwd_valid = 3'b010;
    fwd_pending = 3'b010;
    fwd_addr = {5'd0, 5'd2, 5'd0};
    fwd_data = {64'h0, 64'hCC, 64'h0};
    send(ADD, 64'd5, 64'hCC, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check_eq("haz_raddr1", {59'd0, rf_raddr1}, 64'd1);
      check_eq("haz_raddr2", {59'd0, rf_raddr2}, 64'd2);
      step();
      check_eq("haz_out_valid", {63'd0, out_valid}, 64'd0);
    end
    fwd_pending = 3'b000;
    step();
    check_eq("haz_issue", {63'd0, out_valid}, 64'd1);
`ifdef DECODE_STALL_CNT_EN
    exp_stall = 32'd3;
`else
    exp_stall = 32'd0;
`endif
    check_eq("stall_cycles", {32'd0, stall_cycles}, {32'd0, exp_stall});
    fwd_valid = '0;
    step(); step();

    // backpressure: five inputs fill slot plus all four queue entries
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(ADD, 64'd5, 64'd7, 1'b0);
    check_eq("full_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("full_out_valid", {63'd0, out_valid}, 64'd1);
    step(); step(); step();
    check_eq("still_full", {63'd0, in_ready}, 64'd0);
    base = n_xfer;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check_eq("drain_rate", 64'(n_xfer - base), 64'd5);
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
    step();
    check_eq("drain_idle", {63'd0, out_valid}, 64'd0);

    // illegal encodings still issue, flagged
    send(32'h0000007F, 64'd0, 64'd0, 1'b1);
    send(32'h00000000, 64'd0, 64'd0, 1'b1);
    step(); step(); step();
    check_eq("ill_drained", 64'(sb.size()), 64'd0);

    // flush with three queued entries and a same-cycle offer
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(ADD, 64'd5, 64'd7, 1'b0);
    check_eq("pre_flush_valid", {63'd0, out_valid}, 64'd1);
    sb.delete();
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 64'hF000;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("flush_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    base = n_xfer;
    for (int k = 0; k < 4; k++) step();
    check_eq("flush_nothing_out", 64'(n_xfer - base), 64'd0);
    send(ADD, 64'd5, 64'd7, 1'b0);
    step(); step(); step();
    check_eq("post_flush_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
